// File: rtl/uart_rx_deser_pkg.sv
// Shared UART receive types and constants.
// Used by the deserialiser, its interface and its sub-modules.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_DATA_W    = 8;
    localparam int UART_BIT_CNT_W = 3;

endpackage

// File: rtl/uart_rx_deser_if.sv
// FIFO write-side bundle between the UART deserialiser and the byte FIFO.
// master = deserialiser (writer), slave = FIFO.
interface uart_rx_deser_if;
    import uart_pkg::*;

    logic                   wr;
    logic [UART_DATA_W-1:0] d_out;
    logic                   full;

    modport master (output wr, output d_out, input full);
    modport slave  (input wr, input d_out, output full);

endinterface

// File: rtl/uart_rx_deser_sync_bit.sv
// N-flop synchroniser for one asynchronous input.
// Reset value is an input so idle-high and idle-low lines both fit.
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) r_q <= {N{i_rst_val}};
        else     r_q <= {r_q[N-2:0], i_d};
    end

    assign o_q = r_q[N-1];

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receiver feeding the byte FIFO with one-cycle write strobes.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              clr_err,
    uart_rx_deser_if.master   fifo,
    output logic              overrun,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = '1;

    uart_state_e r_state;
    uart_state_e w_next;

    logic [BAUD_W-1:0]         r_baud;
    logic [UART_BIT_CNT_W-1:0] r_bits;
    logic [UART_DATA_W-1:0]    r_shift;
    logic [UART_DATA_W-1:0]    r_dout;
    logic                      r_wr;
    logic                      r_ovr;
    logic                      r_fe;

    logic w_rx_s;
    logic w_tick;
    logic w_half;
    logic w_shift;
    logic w_stop;
    logic w_good;
    logic w_load;
    logic w_set_ovr;
    logic w_set_fe;
    logic w_pbad;

    sync_bit #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_rst_val(1'b1),
        .i_d      (rx),
        .o_q      (w_rx_s)
    );

    assign w_tick = (r_baud == BAUD_LAST);
    assign w_half = (r_baud == BAUD_HALF);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (!w_rx_s) w_next = START;
            START: if (w_half)  w_next = w_rx_s ? IDLE : DATA;
            DATA: begin
                if (w_tick && r_bits == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
            PARITY: if (w_tick) w_next = STOP;
            STOP:   if (w_tick) w_next = w_rx_s ? IDLE : BREAK;
            BREAK:  if (w_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        w_shift   = (r_state == DATA) && w_tick;
        w_stop    = (r_state == STOP) && w_tick;
        w_good    = w_stop && w_rx_s && !w_pbad;
        w_load    = w_good && !fifo.full;
        w_set_ovr = w_good && fifo.full;
        w_set_fe  = w_stop && !w_rx_s;
    end

    // Any state change restarts the bit-period timer.
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state) || w_tick) r_baud <= '0;
        else                                       r_baud <= r_baud + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != DATA) r_bits <= '0;
        else if (w_shift)           r_bits <= r_bits + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)          r_shift <= '0;
        else if (w_shift) r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_wr <= w_load;
            if (w_load) r_dout <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            if (w_set_ovr)    r_ovr <= 1'b1;
            else if (clr_err) r_ovr <= 1'b0;
            if (w_set_fe)     r_fe  <= 1'b1;
            else if (clr_err) r_fe  <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_pbad;
    logic r_perr;
    logic w_par_x;
    logic w_par_smp;

    assign w_par_x   = (^r_shift) ^ w_rx_s;
    assign w_par_smp = (r_state == PARITY) && w_tick;
    assign w_pbad    = r_pbad;

    // Remembers a bad parity bit until the frame's stop bit is judged.
    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) r_pbad <= 1'b0;
        else if (w_par_smp)         r_pbad <= w_par_x;
    end

    always_ff @(posedge clk) begin
        if (rst)                        r_perr <= 1'b0;
        else if (w_par_smp && w_par_x)  r_perr <= 1'b1;
        else if (clr_err)               r_perr <= 1'b0;
    end

    assign parity_err = r_perr;
`else
    assign w_pbad = 1'b0;
`endif

    assign fifo.wr    = r_wr;
    assign fifo.d_out = r_dout;
    assign overrun    = r_ovr;
    assign frame_err  = r_fe;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser with a byte scoreboard on the FIFO port.
// Build with UART_RX_PARITY_EN to exercise 8E1 frames.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic clr_err = 1'b0;
    logic overrun, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int base;
    logic prev_wr = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_deser_if fifo ();

    uart_rx_deser #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .clr_err   (clr_err),
        .fifo      (fifo),
        .overrun   (overrun),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe pops one expected byte.
    always @(negedge clk) begin
        if (fifo.wr === 1'b1) begin
            wr_cnt++;
            chk("wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {24'd0, fifo.d_out}, 32'hFFFF_FFFF);
            end else begin
                chk("wr_data", {24'd0, fifo.d_out}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_wr = (fifo.wr === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v,
                        input logic bad_par);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = (^b) ^ bad_par;
`ifdef UART_RX_PARITY_EN
        cycles(CPB);
`endif
        rx = stop_v;
        cycles(CPB);
        rx = 1'b1;
    endtask

    task automatic settle();
        cycles(12);
        @(negedge clk);
    endtask

    initial begin
        fifo.full = 1'b0;
        cycles(3);
        @(negedge clk);
        chk("rst_wr", {31'd0, fifo.wr}, 32'd0);
        chk("rst_dout", {24'd0, fifo.d_out}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_fe", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cycles(4);

        base = wr_cnt;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        settle();
        chk("a5_wr_count", wr_cnt - base, 1);
        chk("a5_ovr", {31'd0, overrun}, 32'd0);
        chk("a5_fe", {31'd0, frame_err}, 32'd0);

        base = wr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        settle();
        chk("b2b_wr_count", wr_cnt - base, 3);
        chk("b2b_q_empty", exp_q.size(), 0);

        base = wr_cnt;
        fifo.full = 1'b1;
        send(8'h55, 1'b1, 1'b0);
        settle();
        chk("full_no_wr", wr_cnt - base, 0);
        chk("full_ovr_set", {31'd0, overrun}, 32'd1);
        @(posedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        fifo.full = 1'b0;
        exp_q.push_back(8'h12);
        send(8'h12, 1'b1, 1'b0);
        settle();
        chk("after_full_wr", wr_cnt - base, 1);

        base = wr_cnt;
        send(8'h81, 1'b0, 1'b0);
        rx = 1'b0;
        cycles(24);
        @(negedge clk);
        chk("brk_fe_set", {31'd0, frame_err}, 32'd1);
        chk("brk_busy", {31'd0, busy}, 32'd1);
        chk("brk_no_wr", wr_cnt - base, 0);
        rx = 1'b1;
        cycles(5);
        @(negedge clk);
        chk("brk_released", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1, 1'b0);
        settle();
        chk("after_brk_wr", wr_cnt - base, 1);
        @(posedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("fe_cleared", {31'd0, frame_err}, 32'd0);

        base = wr_cnt;
        @(posedge clk);
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        cycles(30);
        @(negedge clk);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_no_wr", wr_cnt - base, 0);
        chk("glitch_flags", {30'd0, overrun, frame_err}, 32'd0);

        base = wr_cnt;
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC3 >> i) & 8'h01;
            cycles(CPB);
        end
        rx = 1'b0;
        cycles(CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("mid_rst_outs",
            {28'd0, fifo.wr, overrun, frame_err, busy}, 32'd0);
        chk("mid_rst_dout", {24'd0, fifo.d_out}, 32'd0);
        rst = 1'b0;
        cycles(CPB * 12);
        @(negedge clk);
        chk("mid_rst_no_wr", wr_cnt - base, 0);
        exp_q.push_back(8'h99);
        send(8'h99, 1'b1, 1'b0);
        settle();
        chk("post_rst_wr", wr_cnt - base, 1);

`ifdef UART_RX_PARITY_EN
        base = wr_cnt;
        chk("perr_clear", {31'd0, parity_err}, 32'd0);
        send(8'h99, 1'b1, 1'b1);
        settle();
        chk("perr_set", {31'd0, parity_err}, 32'd1);
        chk("perr_no_wr", wr_cnt - base, 0);
        chk("perr_fe", {31'd0, frame_err}, 32'd0);
`endif

        chk("final_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
